// File: rtl/mux8way_arbiter.sv
// mux8way_arbiter: round-robin scheduler driving the select and one-hot grant of a shared 8-way mux.
// Optional hold timeout is compiled in with MUX8WAY_ARB_TIMEOUT_EN.
module mux8way_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [2:0] select,
  output logic [7:0] grant,
  output logic       valid,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d, ptr_q, ptr_d, start, win;
  logic [7:0] grant_q, grant_d, cand;
  logic       found, handoff, load, force_ho;
  assign handoff = state_q == GRANT && (!req[sel_q] || force_ho);
  assign load    = found && (state_q == IDLE || handoff);
  assign start   = handoff ? sel_q + 3'd1 : ptr_q;
  assign cand    = req & ~(handoff ? 8'd1 << sel_q : 8'h00);
  // Scan from the farthest offset down so the last hit is the first set bit after start.
  always_comb begin
    win = start;
    found = 1'b0;
    for (int i = 7; i >= 0; i--)
      if (cand[start + 3'(i)]) begin
        win = start + 3'(i);
        found = 1'b1;
      end
  end
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    grant_d = grant_q;
    ptr_d = handoff ? sel_q + 3'd1 : ptr_q;
    if (load) begin
      state_d = GRANT;
      sel_d = win;
      grant_d = 8'd1 << win;
    end else if (handoff) begin
      state_d = IDLE;
      grant_d = 8'h00;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q <= 3'd0;
      grant_q <= 8'h00;
      ptr_q <= 3'd0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
    end
`ifdef MUX8WAY_ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX);
  localparam logic [CW-1:0] CMAX = CW'(HOLD_MAX - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q;
  assign force_ho = state_q == GRANT && cnt_q == CMAX && req[sel_q] && |(req & ~(8'd1 << sel_q));
  assign cnt_d = load ? '0 : (state_q == GRANT && cnt_q != CMAX) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt_q <= '0;
      to_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q <= force_ho;
    end
  assign timeout = to_q;
`else
  assign force_ho = 1'b0;
  assign timeout = 1'b0;
`endif
  assign select = sel_q;
  assign grant = grant_q;
  assign valid = |grant_q;
endmodule

// File: doc/mux8way_arbiter.md
Name: mux8way_arbiter

Overview:
- Round-robin scheduler that shares one 8-input, 1-bit Mux8way datapath among 8 requesters.
- Drives the mux's 3-bit select and a one-hot grant vector so each requester knows when its input is routed to the shared output.
- Sits directly in front of the Mux8way select input. Requesters hold req high for as long as they need the path.

Parameters:
- HOLD_MAX, 16: maximum consecutive grant cycles when the timeout feature is compiled in. Legal range 2..256. Ignored otherwise.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- req  input  8  request per requester; bit i = Mux8way input i (0=inA ... 7=inH)
- select  output  3  registered select to Mux8way
- grant  output  8  registered one-hot grant, all-zero when idle
- valid  output  1  high while a grant is active (grant != 0)
- timeout  output  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (rst_n low at a clock edge):
  - grant = 0, select = 0, valid = 0, timeout = 0.
  - Round-robin pointer ptr = 0; state = IDLE.
  - Reset overrides all activity, including mid-grant.
- State register: IDLE, GRANT.
- Winner selection (combinational):
  - Scan req starting at index ptr, wrapping 7 -> 0 (mod-8 arithmetic on a 3-bit index).
  - The first set bit wins.
- IDLE:
  - If req != 0 at an edge: that edge loads select = winner, grant = onehot(winner), valid = 1, state = GRANT.
  - Latency is one cycle from req sampled high to grant visible.
  - If req == 0: stay IDLE; select holds its last value; grant = 0.
- GRANT, owner = select:
  - If req[owner] = 1: hold select/grant unchanged (no preemption without the optional feature).
  - If req[owner] = 0 (release): ptr <= owner + 1 mod 8.
    - Then pick the next winner using scan start owner+1 with bit owner masked.
    - If one exists, load it at the same edge: back-to-back handoff, zero idle cycles, state stays GRANT.
    - Else grant = 0, valid = 0, state = IDLE, select holds.
- Fairness:
  - The released owner is scanned last.
  - Any continuously asserted request is granted within 7 handoffs.
- Simultaneous events:
  - A new req arriving in the same cycle as a release is eligible in that scan.
  - A requester that drops and reasserts in the same cycle as its own release is treated as released (scanned last).
- Invariants:
  - grant is always zero or one-hot.
  - When valid = 1, grant == onehot(select).
  - valid == |grant.
- Glitch-free select: select changes only at clock edges and only on a grant change.

Optional Feature:
- Macro: MUX8WAY_ARB_TIMEOUT_EN.
- Enabled:
  - A hold counter (width ceil(log2(HOLD_MAX))) clears on every new grant and increments each GRANT cycle.
  - When count == HOLD_MAX-1, req[owner] is still 1, and any other req bit is set, the next edge performs a forced handoff exactly as a release would (ptr = owner+1, owner masked) and pulses timeout for 1 cycle.
  - If no other requester is waiting, the counter saturates and the grant continues.
- Disabled:
  - No counter is built; timeout is tied to 0.
  - Grants are held indefinitely while req[owner] = 1.

Test Plan:
- Reset: rst_n = 0 for 2 cycles with req = 8'hFF -> grant = 0, select = 0, valid = 0. First edge after release loads grant = 8'h01, select = 0.
- Single requester: req = 8'h20 from IDLE -> next cycle grant = 8'h20, select = 5, valid = 1. Drop req -> next cycle grant = 0, valid = 0, select stays 5.
- Round robin with all requesting: req = 8'hFF, owner releases one cycle after each grant -> select sequence 0,1,2,...,7,0 with no idle cycles between grants.
- Wrap and mask: owner = 7, req = 8'h81, release bit 7 -> next grant = 8'h01 (select = 0). With owner = 3 releasing and req = 8'h08 reasserted the same cycle -> state goes IDLE, then regrants 3.
- Mid-grant reset: while grant = 8'h10, assert rst_n = 0 for 1 cycle -> grant = 0 at that edge, ptr = 0. With req = 8'h12 the next grant is select = 1.
- Timeout (macro defined, HOLD_MAX = 4): req = 8'h03 held high -> grant 0 for 4 cycles, timeout pulse, then grant 1 for 4 cycles, timeout pulse. With the macro undefined, grant 0 is held indefinitely and timeout stays 0.
